// File: rtl/adder_arbiter.sv
// Round-robin arbiter that shares one WIDTH-bit adder between NREQ requesters and returns a registered, tagged sum.
// Optional carry/overflow outputs are enabled by defining ADDER_ARBITER_OVF_EN.
module adder_arbiter #(
  parameter int WIDTH = 32,
  parameter int NREQ  = 4,
  parameter int IDW   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [IDW-1:0]        rsp_id,
  output logic [WIDTH-1:0]      rsp_sum
`ifdef ADDER_ARBITER_OVF_EN
  ,
  output logic                  rsp_cout,
  output logic                  rsp_ovf
`endif
);

  typedef enum logic {EMPTY, FULL} state_e;

  state_e           state_q;
  logic [IDW-1:0]   ptr_q;
  logic [IDW-1:0]   id_q;
  logic [WIDTH-1:0] sum_q;

  logic             slot_free;
  logic             gnt_found;
  logic [IDW-1:0]   gnt_id;
  logic [IDW-1:0]   cand;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] sum_d;

`ifdef ADDER_ARBITER_OVF_EN
  logic             cout_q;
  logic             ovf_q;
  logic             cout_d;
  logic             ovf_d;
  logic [WIDTH:0]   full_sum;
`endif

  // The slot is free when empty or being drained this cycle; reset blocks all grants.
  assign slot_free = !rst && ((state_q == EMPTY) || rsp_ready);

  always_comb begin
    gnt_found = 1'b0;
    gnt_id    = '0;
    cand      = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = IDW'((int'(ptr_q) + k) % NREQ);
      if (!gnt_found && req_valid[cand]) begin
        gnt_found = 1'b1;
        gnt_id    = cand;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (slot_free && gnt_found) begin
      req_ready[gnt_id] = 1'b1;
    end
  end

  assign op_a = req_a[int'(gnt_id)*WIDTH +: WIDTH];
  assign op_b = req_b[int'(gnt_id)*WIDTH +: WIDTH];

`ifdef ADDER_ARBITER_OVF_EN
  assign full_sum = {1'b0, op_a} + {1'b0, op_b};
  assign sum_d    = full_sum[WIDTH-1:0];
  assign cout_d   = full_sum[WIDTH];
  assign ovf_d    = (op_a[WIDTH-1] == op_b[WIDTH-1]) && (sum_d[WIDTH-1] != op_a[WIDTH-1]);
`else
  assign sum_d = op_a + op_b;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      ptr_q   <= '0;
      id_q    <= '0;
      sum_q   <= '0;
`ifdef ADDER_ARBITER_OVF_EN
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
`endif
    end else if (slot_free && gnt_found) begin
      state_q <= FULL;
      id_q    <= gnt_id;
      sum_q   <= sum_d;
      ptr_q   <= (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + IDW'(1);
`ifdef ADDER_ARBITER_OVF_EN
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
`endif
    end else if ((state_q == FULL) && rsp_ready) begin
      // Drain with no refill keeps the old sum and id visible.
      state_q <= EMPTY;
    end
  end

  assign rsp_valid = (state_q == FULL);
  assign rsp_id    = id_q;
  assign rsp_sum   = sum_q;
`ifdef ADDER_ARBITER_OVF_EN
  assign rsp_cout  = cout_q;
  assign rsp_ovf   = ovf_q;
`endif

endmodule

// File: tb/tb_adder_arbiter.sv
// Self-checking bench for adder_arbiter: directed scenarios plus randomized traffic against a behavioural model.
module tb_adder_arbiter;

  localparam int WIDTH = 32;
  localparam int NREQ  = 4;
  localparam int IDW   = 2;

  logic                  clk;
  logic                  rst;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [IDW-1:0]        rsp_id;
  logic [WIDTH-1:0]      rsp_sum;
`ifdef ADDER_ARBITER_OVF_EN
  logic                  rsp_cout;
  logic                  rsp_ovf;
`endif

  adder_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .IDW(IDW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_sum   (rsp_sum)
`ifdef ADDER_ARBITER_OVF_EN
    ,
    .rsp_cout  (rsp_cout),
    .rsp_ovf   (rsp_ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  bit               vld[NREQ];
  logic [WIDTH-1:0] opA[NREQ];
  logic [WIDTH-1:0] opB[NREQ];
  bit               pending[NREQ];

  // Reference model: result slot contents plus the round-robin start position.
  bit               mValid;
  logic [WIDTH-1:0] mSum;
  int               mId;
  int               mPtr;
  bit               mCout;
  bit               mOvf;
  int               lastGrant;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int expectedGrant();
    if (rst) return -1;
    if (mValid && !rsp_ready) return -1;
    for (int k = 0; k < NREQ; k++) begin
      if (vld[(mPtr + k) % NREQ]) return (mPtr + k) % NREQ;
    end
    return -1;
  endfunction

  // One clock cycle: drive, check grant, advance model across the edge, check response.
  task automatic tick();
    int               g;
    logic [NREQ-1:0]  expReady;
    logic [WIDTH:0]   full;
    for (int i = 0; i < NREQ; i++) begin
      req_valid[i]                = vld[i];
      req_a[i*WIDTH +: WIDTH]     = opA[i];
      req_b[i*WIDTH +: WIDTH]     = opB[i];
    end
    #1;
    g = expectedGrant();
    expReady = (g >= 0) ? (NREQ'(1) << g) : '0;
    checkOutput("req_ready", req_ready, expReady);
    @(posedge clk);
    if (rst) begin
      mValid = 0; mSum = '0; mId = 0; mPtr = 0; mCout = 0; mOvf = 0;
    end else if (g >= 0) begin
      full   = {1'b0, opA[g]} + {1'b0, opB[g]};
      mSum   = full[WIDTH-1:0];
      mCout  = full[WIDTH];
      mOvf   = (opA[g][WIDTH-1] == opB[g][WIDTH-1]) && (full[WIDTH-1] != opA[g][WIDTH-1]);
      mValid = 1;
      mId    = g;
      mPtr   = (g + 1) % NREQ;
    end else if (mValid && rsp_ready) begin
      mValid = 0;
    end
    lastGrant = g;
    #1;
    checkOutput("rsp_valid", rsp_valid, mValid);
    checkOutput("rsp_id", rsp_id, mId);
    checkOutput("rsp_sum", rsp_sum, mSum);
`ifdef ADDER_ARBITER_OVF_EN
    checkOutput("rsp_cout", rsp_cout, mCout);
    checkOutput("rsp_ovf", rsp_ovf, mOvf);
`endif
    @(negedge clk);
  endtask

  task automatic applyStimulus(input logic [NREQ-1:0] v, input bit rdy, input bit r);
    for (int i = 0; i < NREQ; i++) vld[i] = v[i];
    rsp_ready = rdy;
    rst       = r;
    tick();
  endtask

  function automatic logic [WIDTH-1:0] randOperand();
    case ($urandom_range(0, 5))
      0:       return '1;
      1:       return {1'b0, {(WIDTH-1){1'b1}}};
      2:       return {1'b1, {(WIDTH-1){1'b0}}};
      default: return WIDTH'($urandom);
    endcase
  endfunction

  initial begin
    rst = 1'b1; rsp_ready = 1'b0; req_valid = '0; req_a = '0; req_b = '0;
    mValid = 0; mSum = '0; mId = 0; mPtr = 0; mCout = 0; mOvf = 0; lastGrant = -1;
    for (int i = 0; i < NREQ; i++) begin
      vld[i] = 0; opA[i] = '0; opB[i] = '0; pending[i] = 0;
    end
    @(negedge clk);
    applyStimulus(4'b0000, 1'b0, 1'b1);
    applyStimulus(4'b1111, 1'b1, 1'b1);

    // Single request right after reset.
    opA[0] = 32'h0040_0000; opB[0] = 32'd4;
    applyStimulus(4'b0001, 1'b1, 1'b0);
    checkOutput("tp1_id", rsp_id, 0);
    checkOutput("tp1_sum", rsp_sum, 32'h0040_0004);

    // Round-robin over all requesters from a fresh pointer.
    applyStimulus(4'b0000, 1'b0, 1'b1);
    for (int i = 0; i < NREQ; i++) begin
      opA[i] = WIDTH'(i); opB[i] = 32'h10;
    end
    for (int k = 0; k < 5; k++) begin
      applyStimulus(4'b1111, 1'b1, 1'b0);
      checkOutput("rr_id", rsp_id, k % NREQ);
      checkOutput("rr_sum", rsp_sum, 32'h10 + (k % NREQ));
    end

    // Back-pressure, then drain-and-refill.
    for (int k = 0; k < 3; k++) begin
      applyStimulus(4'b0110, 1'b0, 1'b0);
      checkOutput("bp_id", rsp_id, 0);
      checkOutput("bp_sum", rsp_sum, 32'h10);
    end
    applyStimulus(4'b0110, 1'b1, 1'b0);
    checkOutput("bp_refill_id", rsp_id, 1);

    // Wrap-around arithmetic.
    opA[0] = 32'hFFFF_FFFF; opB[0] = 32'd1;
    applyStimulus(4'b0001, 1'b1, 1'b0);
    checkOutput("wrap_sum", rsp_sum, 32'h0);
`ifdef ADDER_ARBITER_OVF_EN
    checkOutput("wrap_cout", rsp_cout, 1);
    checkOutput("wrap_ovf", rsp_ovf, 0);
`endif
    opA[0] = 32'h7FFF_FFFF;
    applyStimulus(4'b0001, 1'b1, 1'b0);
    checkOutput("ovf_sum", rsp_sum, 32'h8000_0000);
`ifdef ADDER_ARBITER_OVF_EN
    checkOutput("ovf_cout", rsp_cout, 0);
    checkOutput("ovf_ovf", rsp_ovf, 1);
`endif

    // Reset while a result is held and the pointer sits at 2.
    applyStimulus(4'b0010, 1'b1, 1'b0);
    applyStimulus(4'b0000, 1'b0, 1'b0);
    applyStimulus(4'b0011, 1'b0, 1'b1);
    checkOutput("midrst_valid", rsp_valid, 0);
    checkOutput("midrst_sum", rsp_sum, 0);
    applyStimulus(4'b0011, 1'b1, 1'b0);
    checkOutput("midrst_id", rsp_id, 0);

    // Lone requester after the pointer moves past it.
    applyStimulus(4'b1000, 1'b1, 1'b0);
    checkOutput("lone3_id", rsp_id, 3);
    applyStimulus(4'b0100, 1'b1, 1'b0);
    checkOutput("lone2_id", rsp_id, 2);

    // Random traffic obeying the hold-until-accepted rule.
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!pending[i]) begin
          opA[i] = randOperand();
          opB[i] = randOperand();
          if ($urandom_range(0, 2) == 0) pending[i] = 1;
        end
        vld[i] = pending[i];
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      rst       = ($urandom_range(0, 199) == 0);
      tick();
      if (lastGrant >= 0) pending[lastGrant] = 0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
